// File: rtl/sha256_msg_feed.sv
// Message-word feeder for a SHA-256 core: header register file, nonce counter and block padding.
// Optional: define NONCE_BSWAP_EN to byte-reverse the nonce in header chunk 1 word 3.
module sha256_msg_feed (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hdr_we,
  input  logic [4:0]   hdr_addr,
  input  logic [31:0]  hdr_data,
  input  logic [1:0]   sel,
  input  logic [255:0] digest_in,
  input  logic         nonce_ld,
  input  logic [31:0]  nonce_init,
  input  logic         nonce_inc,
  output logic [31:0]  nonce,
  output logic         nonce_wrap,
  input  logic [3:0]   addr,
  input  logic         rq,
  output logic         rdy,
  output logic [31:0]  data,
  output logic         blk_done
);

  typedef enum logic {IDLE, ACK} state_e;

  state_e      state_q, state_d;
  logic        rdy_q, rdy_d;
  logic [31:0] data_q, data_d;
  logic        last15_q, last15_d;
  logic        blk_done_q, blk_done_d;
  logic [31:0] nonce_q, nonce_d;
  logic        wrap_q, wrap_d;
  logic [31:0] hdr_q [19];
  logic [31:0] hdr_d [19];
  logic [31:0] dig [8];
  logic [31:0] nonce_word;
  logic [31:0] word;

`ifdef NONCE_BSWAP_EN
  assign nonce_word = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
`else
  assign nonce_word = nonce_q;
`endif

  always_comb begin
    for (int unsigned i = 0; i < 8; i++) begin
      dig[i] = digest_in[255 - 32*i -: 32];
    end
  end

  // Word selection uses current-cycle state, so coincident header/nonce updates are seen next fetch.
  always_comb begin
    word = '0;
    case (sel)
      2'd0: word = hdr_q[{1'b0, addr}];
      2'd1: begin
        case (addr)
          4'd0:    word = hdr_q[16];
          4'd1:    word = hdr_q[17];
          4'd2:    word = hdr_q[18];
          4'd3:    word = nonce_word;
          4'd4:    word = 32'h8000_0000;
          4'd15:   word = 32'h0000_0280;
          default: word = '0;
        endcase
      end
      2'd2: begin
        if (addr < 4'd8)        word = dig[addr[2:0]];
        else if (addr == 4'd8)  word = 32'h8000_0000;
        else if (addr == 4'd15) word = 32'h0000_0100;
        else                    word = '0;
      end
      default: word = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rdy_d      = 1'b0;
    data_d     = data_q;
    last15_d   = last15_q;
    blk_done_d = rdy_q & last15_q;
    case (state_q)
      IDLE: begin
        if (rq) begin
          state_d  = ACK;
          rdy_d    = 1'b1;
          data_d   = word;
          last15_d = (addr == 4'd15);
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    wrap_d  = 1'b0;
    nonce_d = nonce_q;
    if (nonce_ld) begin
      nonce_d = nonce_init;
    end else if (nonce_inc) begin
      nonce_d = nonce_q + 32'd1;
      wrap_d  = (nonce_q == '1);
    end

    for (int unsigned i = 0; i < 19; i++) begin
      hdr_d[i] = hdr_q[i];
      if (hdr_we && (hdr_addr == 5'(i))) hdr_d[i] = hdr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rdy_q      <= 1'b0;
      data_q     <= '0;
      last15_q   <= 1'b0;
      blk_done_q <= 1'b0;
      nonce_q    <= '0;
      wrap_q     <= 1'b0;
      for (int unsigned i = 0; i < 19; i++) hdr_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      data_q     <= data_d;
      last15_q   <= last15_d;
      blk_done_q <= blk_done_d;
      nonce_q    <= nonce_d;
      wrap_q     <= wrap_d;
      for (int unsigned i = 0; i < 19; i++) hdr_q[i] <= hdr_d[i];
    end
  end

  assign rdy        = rdy_q;
  assign data       = data_q;
  assign blk_done   = blk_done_q;
  assign nonce      = nonce_q;
  assign nonce_wrap = wrap_q;

endmodule

// File: tb/tb_sha256_msg_feed.sv
// Scoreboard bench for sha256_msg_feed: fetches push expected words, a negedge monitor checks them.
module tb_sha256_msg_feed;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         hdr_we;
  logic [4:0]   hdr_addr;
  logic [31:0]  hdr_data;
  logic [1:0]   sel;
  logic [255:0] digest_in;
  logic         nonce_ld;
  logic [31:0]  nonce_init;
  logic         nonce_inc;
  logic [31:0]  nonce;
  logic         nonce_wrap;
  logic [3:0]   addr;
  logic         rq;
  logic         rdy;
  logic [31:0]  data;
  logic         blk_done;

  sha256_msg_feed dut (
    .clk(clk), .rst_n(rst_n), .hdr_we(hdr_we), .hdr_addr(hdr_addr), .hdr_data(hdr_data),
    .sel(sel), .digest_in(digest_in), .nonce_ld(nonce_ld), .nonce_init(nonce_init),
    .nonce_inc(nonce_inc), .nonce(nonce), .nonce_wrap(nonce_wrap), .addr(addr), .rq(rq),
    .rdy(rdy), .data(data), .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic        is15;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   pulses = 0;
  int   blk_cnt = 0;

  logic [31:0] dw [8] = '{32'h0123_4567, 32'h89AB_CDEF, 32'h1111_2222, 32'h3333_4444,
                          32'h5555_6666, 32'h7777_8888, 32'h9999_AAAA, 32'hCAFE_F00D};

  function automatic logic [31:0] nonce_exp(input logic [31:0] n);
`ifdef NONCE_BSWAP_EN
    return {n[7:0], n[15:8], n[23:16], n[31:24]};
`else
    return n;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on each rdy and tracks the expected blk_done pulse.
  logic prev_rdy = 1'b0;
  logic prev15   = 1'b0;
  always @(negedge clk) begin
    logic cur15;
    exp_t e;
    cur15 = 1'b0;
    if (!rst_n) begin
      prev_rdy = 1'b0;
      prev15   = 1'b0;
    end else begin
      if (rdy) begin
        total++;
        if (prev_rdy) begin
          bad++;
          $display("FAIL rdy_width: rdy high %0d consecutive cycles, required 1", 2);
        end
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_rdy: data=%h with no fetch outstanding", data);
        end else begin
          e = sb.pop_front();
          pulses++;
          cur15 = e.is15;
          if (data !== e.d) begin
            bad++;
            $display("FAIL word: got %h expected %h", data, e.d);
          end
        end
      end
      total++;
      if (blk_done !== (prev_rdy && prev15)) begin
        bad++;
        $display("FAIL blk_done: got %b expected %b", blk_done, prev_rdy && prev15);
      end
      if (blk_done) blk_cnt++;
      prev_rdy = rdy;
      prev15   = rdy ? cur15 : 1'b0;
    end
  end

  task automatic hdr_write(input logic [4:0] a, input logic [31:0] d);
    hdr_we = 1'b1; hdr_addr = a; hdr_data = d;
    @(posedge clk); #1;
    hdr_we = 1'b0;
  endtask

  task automatic fetch(input logic [1:0] s, input logic [3:0] a, input logic [31:0] exp);
    exp_t e;
    e.d = exp; e.is15 = (a == 4'd15);
    sel = s; addr = a; rq = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    rq = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int p0, b0;
    rst_n = 1'b0; hdr_we = 1'b0; hdr_addr = '0; hdr_data = '0; sel = '0;
    nonce_ld = 1'b0; nonce_init = '0; nonce_inc = 1'b0; addr = '0; rq = 1'b0;
    digest_in = {dw[0], dw[1], dw[2], dw[3], dw[4], dw[5], dw[6], dw[7]};
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdy", {31'd0, rdy}, 32'd0);
    check("reset_data", data, 32'd0);
    check("reset_nonce", nonce, 32'd0);
    check("reset_wrap", {31'd0, nonce_wrap}, 32'd0);
    check("reset_blk_done", {31'd0, blk_done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    hdr_write(5'd5, 32'hDEAD_BEEF);
    fetch(2'd0, 4'd5, 32'hDEAD_BEEF);
    hdr_write(5'd3, 32'h3333_3333);
    hdr_write(5'd19, 32'h0BAD_BAD0);
    fetch(2'd0, 4'd3, 32'h3333_3333);
    hdr_write(5'd16, 32'h1111_0000);
    hdr_write(5'd18, 32'h2222_0000);

    nonce_init = 32'h1234_5678; nonce_ld = 1'b1;
    @(posedge clk); #1;
    nonce_ld = 1'b0;
    check("nonce_load", nonce, 32'h1234_5678);

    fetch(2'd1, 4'd0, 32'h1111_0000);
    fetch(2'd1, 4'd2, 32'h2222_0000);
    fetch(2'd1, 4'd3, nonce_exp(32'h1234_5678));
    fetch(2'd1, 4'd4, 32'h8000_0000);
    fetch(2'd1, 4'd7, 32'h0000_0000);
    fetch(2'd1, 4'd15, 32'h0000_0280);

    // Header write coinciding with a fetch of the same word delivers the old value.
    e.d = 32'hDEAD_BEEF; e.is15 = 1'b0;
    sel = 2'd0; addr = 4'd5; rq = 1'b1;
    hdr_we = 1'b1; hdr_addr = 5'd5; hdr_data = 32'hFEED_FACE;
    sb.push_back(e);
    @(posedge clk); #1;
    rq = 1'b0; hdr_we = 1'b0;
    @(posedge clk); #1;
    fetch(2'd0, 4'd5, 32'hFEED_FACE);
    sel = 2'd3; addr = 4'd9;
    repeat (2) @(posedge clk);
    #1;
    check("data_hold", data, 32'hFEED_FACE);

    // Nonce increment coinciding with a fetch of word 3 delivers the pre-increment nonce.
    e.d = nonce_exp(32'h1234_5678); e.is15 = 1'b0;
    sel = 2'd1; addr = 4'd3; rq = 1'b1; nonce_inc = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    rq = 1'b0; nonce_inc = 1'b0;
    @(posedge clk); #1;
    check("nonce_after_inc", nonce, 32'h1234_5679);

    p0 = pulses; b0 = blk_cnt;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      if (i < 8)       w = dw[i];
      else if (i == 8) w = 32'h8000_0000;
      else if (i == 15) w = 32'h0000_0100;
      else             w = 32'h0;
      fetch(2'd2, 4'(i), w);
    end
    @(posedge clk); #1;
    check("burst_pulses", 32'(pulses - p0), 32'd16);
    check("burst_blk_done", 32'(blk_cnt - b0), 32'd1);

    fetch(2'd3, 4'd3, 32'h0);
    fetch(2'd3, 4'd15, 32'h0);

    nonce_init = 32'hFFFF_FFFF; nonce_ld = 1'b1;
    @(posedge clk); #1;
    nonce_ld = 1'b0;
    check("nonce_max", nonce, 32'hFFFF_FFFF);
    check("wrap_on_load", {31'd0, nonce_wrap}, 32'd0);
    nonce_inc = 1'b1;
    @(posedge clk); #1;
    nonce_inc = 1'b0;
    check("nonce_wrapped", nonce, 32'h0);
    check("wrap_pulse", {31'd0, nonce_wrap}, 32'd1);
    @(posedge clk); #1;
    check("wrap_clear", {31'd0, nonce_wrap}, 32'd0);
    nonce_init = 32'hA5A5_A5A5; nonce_ld = 1'b1; nonce_inc = 1'b1;
    @(posedge clk); #1;
    nonce_ld = 1'b0; nonce_inc = 1'b0;
    check("ld_wins", nonce, 32'hA5A5_A5A5);
    check("ld_no_wrap", {31'd0, nonce_wrap}, 32'd0);

    sel = 2'd0; addr = 4'd5; rq = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0; rq = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid_rdy", {31'd0, rdy}, 32'd0);
    check("rst_mid_data", data, 32'h0);
    check("rst_mid_nonce", nonce, 32'h0);
    fetch(2'd0, 4'd5, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule

// File: doc/sha256_msg_feed.md
SHA256_MSG_FEED -- requirements
Module: sha256_msg_feed

Interface
REQ-001 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port hdr_we, input, 1: header word write strobe.
REQ-004 SHALL have port hdr_addr, input, 5: header word index; 0..18 valid.
REQ-005 SHALL have port hdr_data, input, 32: header word to write.
REQ-006 SHALL have port sel, input, 2: block select; 0 = header chunk 0, 1 = header chunk 1 padded, 2 = second-hash block, 3 = reserved.
REQ-007 SHALL have port digest_in, input, 256: first-pass digest, with word 0 in bits [255:224].
REQ-008 SHALL have port nonce_ld, input, 1: load nonce_init into the nonce counter.
REQ-009 SHALL have port nonce_init, input, 32: nonce load value.
REQ-010 SHALL have port nonce_inc, input, 1: increment the nonce counter.
REQ-011 SHALL have port nonce, output, 32: current nonce counter value.
REQ-012 SHALL have port nonce_wrap, output, 1: one-cycle pulse when the counter wraps.
REQ-013 SHALL have port addr, input, 4: word index requested by the SHA core.
REQ-014 SHALL have port rq, input, 1: word request from the SHA core.
REQ-015 SHALL have port rdy, output, 1: word-valid strobe to the SHA core.
REQ-016 SHALL have port data, output, 32: requested message word.
REQ-017 SHALL have port blk_done, output, 1: one-cycle pulse after word 15 is delivered.

Function
REQ-018 SHALL store header words 0..18 in a 19x32 register file written on the edge when hdr_we=1; hdr_addr>=19 SHALL be ignored.
REQ-019 SHALL register the handshake as rdy <= rq & ~rdy, so rdy is a one-cycle pulse issued one cycle after rq is sampled high.
REQ-020 SHALL load data on the same edge that rdy is set; data SHALL hold its value otherwise.
REQ-021 SHALL sample sel, addr, nonce, header and digest_in on that edge; later changes SHALL not affect the delivered word.
REQ-022 SHALL deliver header word addr when sel=0.
REQ-023 SHALL deliver the following when sel=1: words 0..2 = header 16..18; word 3 = nonce; word 4 = 0x80000000; words 5..14 = 0; word 15 = 0x00000280.
REQ-024 SHALL deliver the following when sel=2: words 0..7 = digest_in words; word 8 = 0x80000000; words 9..14 = 0; word 15 = 0x00000100.
REQ-025 SHALL return 0 for every word when sel=3.
REQ-026 SHALL load nonce_init when nonce_ld=1, otherwise increment modulo 2^32 when nonce_inc=1; nonce_ld SHALL win when both are asserted.
REQ-027 SHALL pulse nonce_wrap on the edge where the counter goes from 0xFFFFFFFF to 0 via nonce_inc; a load SHALL never pulse it.
REQ-028 SHALL pulse blk_done one cycle after a rdy pulse that delivered addr=15.
REQ-029 SHALL apply a header write that coincides with a word fetch after the fetch, so the old value is delivered.
REQ-030 SHALL deliver the pre-update nonce when nonce_inc or nonce_ld coincides with a fetch.
REQ-031 SHALL use two states: IDLE (rdy=0) and ACK (rdy=1); IDLE->ACK when rq=1; ACK->IDLE unconditionally.

Reset
REQ-032 SHALL, while rst_n=0, clear rdy, data, blk_done, nonce_wrap, the nonce counter and all header words to 0, and set state to IDLE.
REQ-033 SHALL abandon any in-flight word on reset mid-transfer; no rdy pulse follows the deassertion of rst_n unless rq is sampled again.

Configuration
REQ-034 SHALL byte-reverse the nonce when delivering sel=1 word 3 if NONCE_BSWAP_EN is defined; without the macro, word 3 is the nonce unmodified. The nonce output is never swapped.

Verification
REQ-035 SHALL cover: write header word 5 = 0xDEADBEEF, sel=0, rq with addr=5 -> rdy one cycle later, data=0xDEADBEEF.
REQ-036 SHALL cover: sel=1 with nonce_init=0x12345678 loaded, fetch addr 3/4/15 -> 0x12345678 (0x78563412 with NONCE_BSWAP_EN), then 0x80000000, then 0x00000280.
REQ-037 SHALL cover: sel=2, digest_in word 7 = 0xCAFEF00D, fetch addr 7/8/15 -> 0xCAFEF00D, then 0x80000000, then 0x00000100.
REQ-038 SHALL cover: nonce loaded to 0xFFFFFFFF, then nonce_inc -> nonce=0 and nonce_wrap high for exactly 1 cycle; nonce_ld and nonce_inc together -> nonce=nonce_init.
REQ-039 SHALL cover: a SHA core model fetching 16 words -> 16 rdy pulses, each 1 cycle, with blk_done pulsing once after word 15.
REQ-040 SHALL cover: rst_n low in the cycle after rq -> rdy stays 0, data=0, nonce=0.
